// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W     = 16;
  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_STARVE_MAX = 4;
  localparam int unsigned DEF_TIMEOUT    = 16;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBusyIf = 2'd1,
    StBusyDm = 2'd2,
    StResp   = 2'd3
  } arb_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational winner select: DM has priority unless IF has been starved too long.
module arb_priority_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
  parameter int unsigned CNT_W      = cnt_width(STARVE_MAX)
) (
  input  logic             i_if_req,
  input  logic             i_dm_req,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic             o_gnt_vld,
  output logic             o_gnt_port,
  output logic             o_contested
);

  // Pick the winning port from the current requests and the starvation count.
  always_comb begin
    o_gnt_vld   = i_if_req | i_dm_req;
    o_contested = i_if_req & i_dm_req;
    o_gnt_port  = PORT_IF;
    if (i_dm_req && !(i_if_req && (i_starve_cnt == CNT_W'(STARVE_MAX)))) begin
      o_gnt_port = PORT_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch (IF) and load/store (DM) ports.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err
);

  localparam int unsigned SC_W = cnt_width(STARVE_MAX);
  localparam int unsigned TC_W = cnt_width(TIMEOUT - 1);

  arb_state_t        r_state, w_state_nxt;
  logic [SC_W-1:0]   r_starve_cnt, w_starve_cnt_nxt;
  logic [TC_W-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;
  logic              r_if_gnt, w_if_gnt_nxt, r_dm_gnt, w_dm_gnt_nxt;
  logic              r_if_valid, w_if_valid_nxt, r_dm_valid, w_dm_valid_nxt;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt, r_dm_rdata, w_dm_rdata_nxt;
  logic              r_bus_err, w_bus_err_nxt;
  logic              r_mem_en, w_mem_en_nxt, r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              w_gnt_vld, w_gnt_port, w_contested;
  logic [DATA_W-1:0] w_resp_data;

  arb_priority_sel #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (SC_W)
  ) u_sel (
    .i_if_req     (if_req),
    .i_dm_req     (dm_req),
    .i_starve_cnt (r_starve_cnt),
    .o_gnt_vld    (w_gnt_vld),
    .o_gnt_port   (w_gnt_port),
    .o_contested  (w_contested)
  );

  // Stores return zero; r_mem_we is only ever set for a DM store.
  assign w_resp_data = r_mem_we ? '0 : mem_rdata;

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_starve_cnt_nxt = r_starve_cnt;
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_if_gnt_nxt     = 1'b0;
    w_dm_gnt_nxt     = 1'b0;
    w_if_valid_nxt   = 1'b0;
    w_dm_valid_nxt   = 1'b0;
    w_bus_err_nxt    = 1'b0;
    w_if_rdata_nxt   = r_if_rdata;
    w_dm_rdata_nxt   = r_dm_rdata;
    w_mem_en_nxt     = r_mem_en;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    unique case (r_state)
      StIdle: begin
        if (w_gnt_vld) begin
          w_mem_en_nxt = 1'b1;
          if (w_gnt_port == PORT_DM) begin
            w_state_nxt     = StBusyDm;
            w_dm_gnt_nxt    = 1'b1;
            w_mem_we_nxt    = dm_we;
            w_mem_addr_nxt  = dm_addr;
            w_mem_wdata_nxt = dm_wdata;
            if (w_contested && (r_starve_cnt != SC_W'(STARVE_MAX))) begin
              w_starve_cnt_nxt = r_starve_cnt + 1'b1;
            end
          end else begin
            w_state_nxt      = StBusyIf;
            w_if_gnt_nxt     = 1'b1;
            w_mem_we_nxt     = 1'b0;
            w_mem_addr_nxt   = if_addr;
            w_mem_wdata_nxt  = '0;
            w_starve_cnt_nxt = '0;
          end
        end
      end
      StBusyIf, StBusyDm: begin
        if (mem_ready || (r_tmo_cnt == TC_W'(TIMEOUT - 1))) begin
          w_state_nxt   = StResp;
          w_mem_en_nxt  = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_bus_err_nxt = ~mem_ready;
          if (r_state == StBusyDm) begin
            w_dm_valid_nxt = 1'b1;
            w_dm_rdata_nxt = mem_ready ? w_resp_data : '0;
          end else begin
            w_if_valid_nxt = 1'b1;
            w_if_rdata_nxt = mem_ready ? w_resp_data : '0;
          end
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
        end
      end
      StResp: begin
        w_tmo_cnt_nxt = '0;
        w_state_nxt   = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State, counters and output registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_if_gnt     <= 1'b0;
      r_dm_gnt     <= 1'b0;
      r_if_valid   <= 1'b0;
      r_dm_valid   <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_bus_err    <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_if_gnt     <= w_if_gnt_nxt;
      r_dm_gnt     <= w_dm_gnt_nxt;
      r_if_valid   <= w_if_valid_nxt;
      r_dm_valid   <= w_dm_valid_nxt;
      r_if_rdata   <= w_if_rdata_nxt;
      r_dm_rdata   <= w_dm_rdata_nxt;
      r_bus_err    <= w_bus_err_nxt;
      r_mem_en     <= w_mem_en_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  assign if_gnt    = r_if_gnt;
  assign dm_gnt    = r_dm_gnt;
  assign if_valid  = r_if_valid;
  assign dm_valid  = r_dm_valid;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign bus_err   = r_bus_err;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int SMAX = 4;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, dm_req, dm_we, mem_ready;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic          if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we, bus_err;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX),
    .TIMEOUT    (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_valid  (dm_valid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state: outstanding requests and the fetch starvation count.
  int            starve = 0;
  bit            if_pend = 1'b0, dm_pend = 1'b0, dm_w = 1'b0;
  logic [AW-1:0] if_a, dm_a;
  logic [DW-1:0] dm_wd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, {if_gnt, dm_gnt, if_valid, dm_valid, bus_err, mem_en, mem_we}, 32'h0);
  endtask

  task automatic issue_if(input logic [AW-1:0] a);
    if_pend = 1'b1; if_a = a;
    if_req  = 1'b1; if_addr = a;
  endtask

  task automatic issue_dm(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    dm_pend = 1'b1; dm_w = we; dm_a = a; dm_wd = wd;
    dm_req  = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
  endtask

  // One arbitration: called in an IDLE cycle, returns in the next IDLE cycle.
  // lat_sel < 0 picks a random latency; lat_sel >= TMO means memory never answers.
  task automatic arb_round(input bit allow_new, input bit force_both, input int lat_sel,
                           input bit use_rd, input logic [DW-1:0] rd_fixed, output bit win_dm);
    bit            timed_out;
    int            lat, nbusy;
    logic [DW-1:0] rd, exp_rd;
    win_dm = 1'b0;
    if (force_both) begin
      if (!if_pend) issue_if(AW'($urandom));
      if (!dm_pend) issue_dm(1'($urandom), AW'($urandom), DW'($urandom));
    end else if (allow_new) begin
      if (!if_pend && $urandom_range(0, 1) == 1) issue_if(AW'($urandom));
      if (!dm_pend && $urandom_range(0, 1) == 1) issue_dm(1'($urandom), AW'($urandom), DW'($urandom));
    end
    // mem_ready outside a busy state must be ignored
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = DW'($urandom);
    if (!if_pend && !dm_pend) begin
      next_cyc();
      check_quiet("no_req");
      return;
    end
    if (if_pend && dm_pend) begin
      if (starve == SMAX) begin win_dm = 1'b0; starve = 0; end
      else begin win_dm = 1'b1; starve++; end
    end else if (if_pend) begin
      win_dm = 1'b0; starve = 0;
    end else begin
      win_dm = 1'b1;
    end
    if (lat_sel < 0) lat = ($urandom_range(0, 11) == 0) ? TMO : int'($urandom_range(0, 3));
    else lat = lat_sel;
    timed_out = (lat >= TMO);
    nbusy     = timed_out ? TMO : lat + 1;
    rd        = '0;
    for (int k = 0; k < nbusy; k++) begin
      next_cyc();
      check_eq("if_gnt", if_gnt, (!win_dm && k == 0));
      check_eq("dm_gnt", dm_gnt, (win_dm && k == 0));
      check_eq("mem_en", mem_en, 1);
      check_eq("mem_addr", mem_addr, win_dm ? dm_a : if_a);
      check_eq("mem_we", mem_we, win_dm && dm_w);
      if (win_dm && dm_w) check_eq("mem_wdata", mem_wdata, dm_wd);
      check_eq("busy_valid", {if_valid, dm_valid, bus_err}, 0);
      rd        = use_rd ? rd_fixed : DW'($urandom);
      mem_rdata = rd;
      mem_ready = !timed_out && (k == lat);
    end
    next_cyc();
    exp_rd    = (timed_out || (win_dm && dm_w)) ? '0 : rd;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = DW'($urandom);
    check_eq("if_valid", if_valid, !win_dm);
    check_eq("dm_valid", dm_valid, win_dm);
    check_eq("rdata", win_dm ? dm_rdata : if_rdata, exp_rd);
    check_eq("bus_err", bus_err, timed_out);
    check_eq("resp_mem_en", {mem_en, if_gnt, dm_gnt}, 0);
    if (win_dm) begin dm_pend = 1'b0; dm_req = 1'b0; end
    else begin if_pend = 1'b0; if_req = 1'b0; end
    next_cyc();
    check_quiet("post_resp");
  endtask

  task automatic drain();
    bit w;
    for (int i = 0; i < 2; i++) if (if_pend || dm_pend) arb_round(1'b0, 1'b0, 1, 1'b0, '0, w);
  endtask

  initial begin
    bit w;
    reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    #20;
    check_quiet("rst_hold");
    check_eq("rst_rdata", {if_rdata, dm_rdata}, 0);
    #30;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      check_quiet("rst_idle");
    end

    // Zero-wait IF read
    issue_if(16'h0004);
    arb_round(1'b0, 1'b0, 0, 1'b1, 16'h2011, w);
    // DM store, memory ready on the 4th busy cycle
    issue_dm(1'b1, 16'h0010, 16'hBEEF);
    arb_round(1'b0, 1'b0, 3, 1'b0, '0, w);

    // Both ports always requesting: IF wins every 5th arbitration
    for (int i = 0; i < 10; i++) begin
      arb_round(1'b0, 1'b1, int'($urandom_range(0, 2)), 1'b0, '0, w);
      check_eq("starve_seq", w, (i % 5) != 4);
    end
    drain();

    // IF read that never gets mem_ready, then a normal one
    issue_if(AW'($urandom));
    arb_round(1'b0, 1'b0, TMO, 1'b0, '0, w);
    issue_if(AW'($urandom));
    arb_round(1'b0, 1'b0, 1, 1'b0, '0, w);

    for (int i = 0; i < 150; i++) arb_round(1'b1, 1'b0, -1, 1'b0, '0, w);
    drain();

    // Reset asserted during a DM access
    issue_dm(1'b0, 16'h0200, '0);
    mem_ready = 1'b0;
    next_cyc();
    check_eq("mid_gnt", {dm_gnt, mem_en}, 2'b11);
    next_cyc();
    #3;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_async", {dm_gnt, mem_en, dm_valid}, 0);
    dm_req = 1'b0; dm_pend = 1'b0; starve = 0;
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      check_quiet("mid_rst_hold");
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cyc();
      check_quiet("mid_rst_rel");
    end
    issue_dm(1'b0, 16'h0123, '0);
    arb_round(1'b0, 1'b0, 0, 1'b1, 16'h5A5A, w);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
